// File: rtl/ines_loader_if.sv
// rtl/ines_loader_if.sv - image byte stream, PRG/CHR write ports and status of ines_loader
// master drives the image stream and start; slave is the loader.
interface ines_loader_if;
   logic        start;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        prg_we;
   logic [14:0] prg_addr;
   logic [7:0]  prg_wdata;
   logic        chr_we;
   logic [12:0] chr_addr;
   logic [7:0]  chr_wdata;
   logic [1:0]  prg_banks;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_code;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, prg_we, prg_addr, prg_wdata, chr_we, chr_addr, chr_wdata,
      input  prg_banks, busy, done, error, err_code
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, prg_we, prg_addr, prg_wdata, chr_we, chr_addr, chr_wdata,
      output prg_banks, busy, done, error, err_code
   );
endinterface

// File: rtl/ines_loader.sv
// rtl/ines_loader.sv - iNES mapper-0 image stream to PRG/CHR memory writer
// Define INES_TRAINER_SKIP_EN to discard a 512-byte trainer instead of rejecting the image.
module ines_loader #(
   parameter int MAX_PRG_BANKS = 2,
   parameter int MAX_CHR_BANKS = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   ines_loader_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_TRAIN, S_PRG, S_CHR, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] MAGIC   = 32'h1A53_454E;
   localparam logic [7:0]  MAX_PRG = 8'(MAX_PRG_BANKS);
   localparam logic [7:0]  MAX_CHR = 8'(MAX_CHR_BANKS);

   state_t      r_state, w_state;
   logic [15:0] r_idx, w_idx;
   logic [7:0]  r_prg_cnt, w_prg_cnt;
   logic [7:0]  r_chr_cnt, w_chr_cnt;
   logic [3:0]  r_mapper_lo, w_mapper_lo;
   logic        r_trainer, w_trainer;
   logic        r_in_ready;
   logic        r_busy;
   logic        r_prg_we, w_prg_we;
   logic [14:0] r_prg_addr, w_prg_addr;
   logic [7:0]  r_prg_wdata, w_prg_wdata;
   logic        r_chr_we, w_chr_we;
   logic [12:0] r_chr_addr, w_chr_addr;
   logic [7:0]  r_chr_wdata, w_chr_wdata;
   logic [1:0]  r_prg_banks, w_prg_banks;
   logic        r_done, w_done;
   logic        r_error, w_error;
   logic [1:0]  r_err_code, w_err_code;
   logic        w_accept, w_prg_last, w_streaming;

   assign w_accept    = bus.in_valid & r_in_ready;
   assign w_prg_last  = (r_idx == ({r_prg_banks, 14'd0} - 16'd1));
   // ready/busy are registered from the next state so they never depend on in_valid
   assign w_streaming = (w_state == S_HDR) || (w_state == S_TRAIN) ||
                        (w_state == S_PRG) || (w_state == S_CHR);

   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_prg_cnt   = r_prg_cnt;
      w_chr_cnt   = r_chr_cnt;
      w_mapper_lo = r_mapper_lo;
      w_trainer   = r_trainer;
      w_prg_we    = 1'b0;
      w_prg_addr  = r_prg_addr;
      w_prg_wdata = r_prg_wdata;
      w_chr_we    = 1'b0;
      w_chr_addr  = r_chr_addr;
      w_chr_wdata = r_chr_wdata;
      w_prg_banks = r_prg_banks;
      w_done      = r_done;
      w_error     = r_error;
      w_err_code  = r_err_code;
      if (bus.start) begin
         w_state    = S_HDR;
         w_done     = 1'b0;
         w_error    = 1'b0;
         w_err_code = 2'd0;
      end else if (w_accept) begin
         w_idx = r_idx + 16'd1;
         unique case (r_state)
            S_HDR: begin
               if (r_idx < 16'd4 && bus.in_data != MAGIC[{r_idx[1:0], 3'b000} +: 8]) begin
                  w_state    = S_ERR;
                  w_error    = 1'b1;
                  w_err_code = 2'd1;
               end
               case (r_idx)
                  16'd4: begin
                     w_prg_cnt   = bus.in_data;
                     w_prg_banks = bus.in_data[1:0];
                  end
                  16'd5: w_chr_cnt = bus.in_data;
                  16'd6: begin
                     w_trainer   = bus.in_data[2];
                     w_mapper_lo = bus.in_data[7:4];
                  end
                  16'd7: begin
                     if (r_prg_cnt == 8'd0 || r_prg_cnt > MAX_PRG || r_chr_cnt > MAX_CHR ||
                         r_mapper_lo != 4'd0 || bus.in_data[7:4] != 4'd0) begin
                        w_state    = S_ERR;
                        w_error    = 1'b1;
                        w_err_code = 2'd2;
                     end
                  end
                  16'd15: begin
                     if (r_trainer) begin
`ifdef INES_TRAINER_SKIP_EN
                        w_state = S_TRAIN;
`else
                        w_state    = S_ERR;
                        w_error    = 1'b1;
                        w_err_code = 2'd3;
`endif
                     end else begin
                        w_state = S_PRG;
                     end
                  end
                  default: ;
               endcase
            end
`ifdef INES_TRAINER_SKIP_EN
            S_TRAIN: begin
               if (r_idx == 16'd511) w_state = S_PRG;
            end
`endif
            S_PRG: begin
               w_prg_we    = 1'b1;
               w_prg_addr  = r_idx[14:0];
               w_prg_wdata = bus.in_data;
               if (w_prg_last) begin
                  if (r_chr_cnt != 8'd0) begin
                     w_state = S_CHR;
                  end else begin
                     w_state = S_DONE;
                     w_done  = 1'b1;
                  end
               end
            end
            S_CHR: begin
               w_chr_we    = 1'b1;
               w_chr_addr  = r_idx[12:0];
               w_chr_wdata = bus.in_data;
               if (r_idx == 16'd8191) begin
                  w_state = S_DONE;
                  w_done  = 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (bus.start || w_state != r_state) w_idx = 16'd0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= 16'd0;
         r_prg_cnt   <= 8'd0;
         r_chr_cnt   <= 8'd0;
         r_mapper_lo <= 4'd0;
         r_trainer   <= 1'b0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_prg_we    <= 1'b0;
         r_prg_addr  <= 15'd0;
         r_prg_wdata <= 8'd0;
         r_chr_we    <= 1'b0;
         r_chr_addr  <= 13'd0;
         r_chr_wdata <= 8'd0;
         r_prg_banks <= 2'd0;
         r_done      <= 1'b0;
         r_error     <= 1'b0;
         r_err_code  <= 2'd0;
      end else begin
         r_state     <= w_state;
         r_idx       <= w_idx;
         r_prg_cnt   <= w_prg_cnt;
         r_chr_cnt   <= w_chr_cnt;
         r_mapper_lo <= w_mapper_lo;
         r_trainer   <= w_trainer;
         r_in_ready  <= w_streaming;
         r_busy      <= w_streaming;
         r_prg_we    <= w_prg_we;
         r_prg_addr  <= w_prg_addr;
         r_prg_wdata <= w_prg_wdata;
         r_chr_we    <= w_chr_we;
         r_chr_addr  <= w_chr_addr;
         r_chr_wdata <= w_chr_wdata;
         r_prg_banks <= w_prg_banks;
         r_done      <= w_done;
         r_error     <= w_error;
         r_err_code  <= w_err_code;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.prg_we    = r_prg_we;
   assign bus.prg_addr  = r_prg_addr;
   assign bus.prg_wdata = r_prg_wdata;
   assign bus.chr_we    = r_chr_we;
   assign bus.chr_addr  = r_chr_addr;
   assign bus.chr_wdata = r_chr_wdata;
   assign bus.prg_banks = r_prg_banks;
   assign bus.busy      = r_busy;
   assign bus.done      = r_done;
   assign bus.error     = r_error;
   assign bus.err_code  = r_err_code;
endmodule

// File: tb/tb_ines_loader.sv
// tb/tb_ines_loader.sv - randomized image loads of ines_loader against an iNES header model
// Honours INES_TRAINER_SKIP_EN the same way as the design.
module tb_ines_loader;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   n_prg = 0;
   int   n_chr = 0;
   int   base_prg, base_chr;
   logic [7:0] img[$];
   logic [7:0] prg_mem [32768];
   logic [7:0] chr_mem [8192];

   ines_loader_if bus();
   ines_loader dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.prg_we) begin
         prg_mem[bus.prg_addr] = bus.prg_wdata;
         n_prg++;
      end
      if (bus.chr_we) begin
         chr_mem[bus.chr_addr] = bus.chr_wdata;
         n_chr++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " in_ready"},  32'(bus.in_ready),  32'd0);
      chk({tag, " prg_we"},    32'(bus.prg_we),    32'd0);
      chk({tag, " prg_addr"},  32'(bus.prg_addr),  32'd0);
      chk({tag, " prg_wdata"}, 32'(bus.prg_wdata), 32'd0);
      chk({tag, " chr_we"},    32'(bus.chr_we),    32'd0);
      chk({tag, " chr_addr"},  32'(bus.chr_addr),  32'd0);
      chk({tag, " chr_wdata"}, 32'(bus.chr_wdata), 32'd0);
      chk({tag, " prg_banks"}, 32'(bus.prg_banks), 32'd0);
      chk({tag, " busy"},      32'(bus.busy),      32'd0);
      chk({tag, " done"},      32'(bus.done),      32'd0);
      chk({tag, " error"},     32'(bus.error),     32'd0);
      chk({tag, " err_code"},  32'(bus.err_code),  32'd0);
   endtask

   // header, then `body` random bytes
   task automatic make_img(input logic [7:0] p, input logic [7:0] c, input logic [7:0] f6,
                           input logic [7:0] f7, input int body);
      img.delete();
      img.push_back(8'h4E); img.push_back(8'h45); img.push_back(8'h53); img.push_back(8'h1A);
      img.push_back(p); img.push_back(c); img.push_back(f6); img.push_back(f7);
      for (int k = 0; k < 8 + body; k++) img.push_back(8'($urandom_range(255)));
   endtask

   // Outcome of loading img: error code, bytes consumed, PRG file offset, write counts.
   function automatic void model(output int code, output int stop, output int prg_off,
                                 output int n_p, output int n_c);
      logic [7:0] magic [4];
      logic [7:0] mapper;
      magic = '{8'h4E, 8'h45, 8'h53, 8'h1A};
      code = 0; stop = 0; prg_off = 16; n_p = 0; n_c = 0;
      for (int k = 0; k < 4; k++)
         if (code == 0 && img[k] != magic[k]) begin
            code = 1;
            stop = k + 1;
         end
      if (code != 0) return;
      mapper = {img[7][7:4], img[6][7:4]};
      if (img[4] == 8'd0 || img[4] > 8'd2 || img[5] > 8'd1 || mapper != 8'd0) begin
         code = 2;
         stop = 8;
         return;
      end
      if (img[6][2]) begin
`ifdef INES_TRAINER_SKIP_EN
         prg_off = 16 + 512;
`else
         code = 3;
         stop = 16;
         return;
`endif
      end
      n_p  = int'(img[4]) * 16384;
      n_c  = int'(img[5]) * 8192;
      stop = prg_off + n_p + n_c;
   endfunction

   task automatic kick();
      @(negedge clk);
      bus.start = 1'b1;
      base_prg  = n_prg;
      base_chr  = n_chr;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   // Offers img bytes with random gaps until n are accepted or a status rises;
   // returns at the negedge right after the last accepting edge.
   task automatic feed(input int n, input int gap, output int acc, output bit prev_acc);
      int budget;
      bit pend;
      budget = 4 * n + 100;
      acc = 0; prev_acc = 1'b0; pend = 1'b0;
      forever begin
         @(negedge clk);
         prev_acc = pend;
         if (pend) acc++;
         pend = 1'b0;
         if (acc >= n || bus.error || bus.done || budget == 0) break;
         budget--;
         bus.in_valid = (int'($urandom_range(99)) >= gap);
         bus.in_data  = img[acc];
         pend = bus.in_valid && bus.in_ready;
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic run_load(input int gap, input string tag);
      int code, stop, prg_off, n_p, n_c, acc, mism;
      bit prev;
      model(code, stop, prg_off, n_p, n_c);
      kick();
      feed(stop, gap, acc, prev);
      chk({tag, " bytes accepted"}, 32'(acc), 32'(stop));
      chk({tag, " status one cycle after last byte"}, 32'(prev), 32'd1);
      chk({tag, " in_ready"}, 32'(bus.in_ready), 32'd0);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " done"}, 32'(bus.done), 32'(code == 0));
      chk({tag, " error"}, 32'(bus.error), 32'(code != 0));
      chk({tag, " err_code"}, 32'(bus.err_code), 32'(code));
      if (code == 0)
         chk({tag, " last strobe with done"}, 32'(n_c != 0 ? bus.chr_we : bus.prg_we), 32'd1);
      repeat (2) @(negedge clk);
      chk({tag, " prg strobes"}, 32'(n_prg - base_prg), 32'(n_p));
      chk({tag, " chr strobes"}, 32'(n_chr - base_chr), 32'(n_c));
      mism = 0;
      for (int i = 0; i < n_p; i++) if (prg_mem[15'(i)] !== img[prg_off + i]) mism++;
      for (int i = 0; i < n_c; i++) if (chr_mem[13'(i)] !== img[prg_off + n_p + i]) mism++;
      chk({tag, " data mismatches"}, 32'(mism), 32'd0);
   endtask

   initial begin
      int acc;
      bit prev;
      logic [7:0] b;

      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h4E;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      bus.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle in_ready", 32'(bus.in_ready), 32'd0);
      chk("idle busy", 32'(bus.busy), 32'd0);
      bus.in_valid = 1'b0;

      make_img(8'd2, 8'd1, 8'h00, 8'h00, 32768 + 8192);
      run_load(0, "nrom256");
      chk("nrom256 prg_banks", 32'(bus.prg_banks), 32'd2);
      chk("nrom256 offset 0x4010 at 0x4000", 32'(prg_mem[15'h4000]), 32'(img[16'h4010]));

      make_img(8'd1, 8'd0, 8'h00, 8'h00, 16384);
      run_load(20, "nrom128");
      chk("nrom128 prg_banks", 32'(bus.prg_banks), 32'd1);

      make_img(8'd2, 8'd1, 8'h00, 8'h00, 32);
      img[2] = 8'h54;
      run_load(0, "bad magic");

      make_img(8'd1, 8'd1, 8'h10, 8'h00, 32);
      run_load(10, "mapper 1");

      make_img(8'd3, 8'd0, 8'h00, 8'h00, 32);
      run_load(0, "prg 3 banks");

      make_img(8'd1, 8'd0, 8'h04, 8'h00, 512 + 16384);
`ifdef INES_TRAINER_SKIP_EN
      kick();
      feed(529, 0, acc, prev);
      chk("trainer bytes accepted", 32'(acc), 32'd529);
      chk("trainer first prg_we", 32'(bus.prg_we), 32'd1);
      chk("trainer first prg_addr", 32'(bus.prg_addr), 32'd0);
      chk("trainer first prg_wdata", 32'(bus.prg_wdata), 32'(img[528]));
      chk("trainer no strobes before prg", 32'(n_prg - base_prg), 32'd0);
`else
      run_load(0, "trainer");
`endif

      make_img(8'd1, 8'd0, 8'h00, 8'h00, 16384);
      kick();
      feed(16 + 100, 0, acc, prev);
      chk("abort bytes accepted", 32'(acc), 32'd116);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("abort in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort busy", 32'(bus.busy), 32'd1);
      chk("abort prg_we", 32'(bus.prg_we), 32'd0);
      b = 8'($urandom_range(255));
      if (b == 8'h4E) b = 8'h4F;
      bus.in_data = b;
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("abort byte0 error", 32'(bus.error), 32'd1);
      chk("abort byte0 err_code", 32'(bus.err_code), 32'd1);

      make_img(8'd1, 8'd1, 8'h00, 8'h00, 16384 + 8192);
      kick();
      feed(16 + 16384 + 100, 0, acc, prev);
      chk("midchr bytes accepted", 32'(acc), 32'(16 + 16384 + 100));
      chk("midchr chr_we pending", 32'(bus.chr_we), 32'd1);
      rst_n = 1'b0;
      bus.start = 1'b1;
      bus.in_valid = 1'b1;
      @(negedge clk);
      check_reset_outputs("midchr reset");
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("midchr chr strobes", 32'(n_chr - base_chr), 32'd100);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ines_loader.md
# ines_loader

Streaming writer that fills the cartridge PRG and CHR memories from a byte stream of an iNES (mapper 0 / NROM) image, the write-side counterpart of `rom_master`, which only reads those memories. Sits between the image source (UART/SD/host FIFO) and the PRG/CHR memory write ports. It parses the 16-byte header, optionally discards a trainer, then writes PRG bytes followed by CHR bytes. It reports the PRG bank count so the CPU-side decode can mirror $8000/$C000.

## Interface
- `MAX_PRG_BANKS`, 2, largest accepted header byte 4 (16 KiB units).
- `MAX_CHR_BANKS`, 1, largest accepted header byte 5 (8 KiB units).
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  one-cycle pulse: clear status, enter HDR.
- `in_data`  in  8  image byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  byte accepted on a cycle with `in_valid & in_ready`.
- `prg_we`  out  1  PRG write strobe.
- `prg_addr`  out  15  PRG byte address, 0..0x7FFF.
- `prg_wdata`  out  8  PRG write data.
- `chr_we`  out  1  CHR write strobe.
- `chr_addr`  out  13  CHR byte address, 0..0x1FFF.
- `chr_wdata`  out  8  CHR write data.
- `prg_banks`  out  2  PRG bank count latched from the header.
- `busy`  out  1  high in HDR/TRAIN/PRG/CHR.
- `done`  out  1  level; image loaded.
- `error`  out  1  level; load aborted.
- `err_code`  out  2  1 bad magic, 2 unsupported size/mapper, 3 trainer present and unsupported.

## Operation
- States: IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR. `in_ready` = 1 in HDR, TRAIN, PRG and CHR; 0 otherwise.
- 16-bit `idx` counts accepted bytes within the current state and is cleared on every state change.
- HDR:
  - Bytes 0–3 must be 0x4E, 0x45, 0x53, 0x1A. A mismatch sets ERR with code 1 on the cycle after the bad byte is accepted.
  - Byte 4 is the PRG bank count; byte 5 the CHR bank count; byte 6 bit 2 is the trainer flag; byte 6[7:4] and byte 7[7:4] form the mapper number. Bytes 8–15 are ignored.
  - After byte 7 is accepted, ERR with code 2 is entered if PRG = 0, PRG > `MAX_PRG_BANKS`, CHR > `MAX_CHR_BANKS`, or mapper ≠ 0.
  - After byte 15: go to TRAIN if the trainer flag is set, else PRG.
- TRAIN: see Configuration.
- PRG:
  - Accepted byte n writes `prg_addr` = n, `prg_wdata` = byte.
  - Exits after `prg_banks` × 16384 bytes: to CHR if CHR ≠ 0, else DONE. CHR = 0 means CHR-RAM; no CHR writes occur.
- CHR: byte n writes `chr_addr` = n; exits after 8192 bytes to DONE.
- DONE/ERR: hold, stream stalled, until `start`.
- `start` in any state, including mid-load, aborts and enters HDR with `done`, `error`, `err_code` and `idx` cleared. Memory already written is not cleared.
- `prg_banks` holds its value until the next header byte 4 is accepted.

## Timing
- All outputs are registered. Reset values: `in_ready` 0, `prg_we`/`chr_we` 0, addresses and data 0, `prg_banks` 0, `busy` 0, `done` 0, `error` 0, `err_code` 0; state IDLE.
- Throughput: one byte per cycle. `in_ready` has no combinational path from `in_valid`.
- Write latency: a byte accepted at edge k drives `*_we`/addr/data for exactly the cycle after edge k (one clock wide, one strobe per accepted byte).
- The last CHR (or PRG, if CHR = 0) write strobe and `done` rise together. `in_ready` is already low in that cycle.
- Status outputs change on the edge after the deciding byte is accepted.
- Synchronous reset wins over `start` and `in_valid` on the same edge; a pending write strobe is dropped.

## Configuration
- `INES_TRAINER_SKIP_EN` defined: TRAIN accepts and discards 512 bytes (no write strobes), then enters PRG.
- Undefined: a set trainer flag enters ERR with code 3 after byte 15. TRAIN is unreachable.

## Test plan
- Valid NROM-256 header (`4E 45 53 1A 02 01 00 00 …`) + 32768 + 8192 bytes with in_valid held high -> 32768 `prg_we` strobes at addr 0..0x7FFF, then 8192 `chr_we` strobes; `prg_banks` = 2. The byte at file offset 0x4010 (16 + 16384) lands at `prg_addr` 0x4000. `done` = 1 one cycle after the last byte.
- NROM-128 (PRG = 1, CHR = 0) with random `in_valid` gaps -> 16384 PRG writes, no `chr_we`; `done` = 1; `prg_banks` = 1. Data matches source byte-for-byte.
- Byte 2 = 0x54 -> `error` = 1, `err_code` = 1 one cycle after acceptance; `in_ready` = 0; no write strobes.
- Byte 6 = 0x10 (mapper 1) -> `err_code` = 2 after byte 7. Separately, byte 4 = 3 -> `err_code` = 2.
- Byte 6 = 0x04: with `INES_TRAINER_SKIP_EN`, the first PRG write carries file byte 528; without it, `err_code` = 3.
- `start` pulse at PRG byte 100 -> `idx` cleared, state HDR, the next accepted byte is checked against 0x4E. A `rst_n` low mid-CHR -> all outputs at reset values on the next edge.
